rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader.sv | 175 +++++++++++++++++
 tb/tb_rom_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_reader.sv
// Burst reader for a synchronous ROM: issues credit-limited reads and streams words out through a small FIFO.
// Optional request bound check enabled by defining ROM_READER_BOUND_CHECK_EN.
module rom_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [19:0] REQ_ADDR,
  input  logic [9:0]  REQ_LEN,
  output logic [19:0] ROM_A,
  output logic        ROM_OE,
  input  logic [15:0] ROM_Q,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic [15:0] DOUT_DATA,
  output logic        DOUT_LAST,
  output logic        BUSY,
  output logic        ERR,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Handshakes: REQ and DOUT both transfer on the CK edge where valid and ready are 1;
  // a valid producer holds its payload stable until that edge.

  state_t          state_q, state_d;
  logic [19:0]     rom_a_q, rom_a_d;
  logic            rom_oe_q, rom_oe_d;
  logic [9:0]      cnt_q, cnt_d;
  logic            tag_v_q, tag_v_d;
  logic            tag_last_q, tag_last_d;
  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [16:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            reject;
  logic            push;
  logic            pop;
  logic            head_last;
  logic [CW:0]     used;
  logic            credit;
  logic            issue;

  assign accept    = REQ_VALID && (state_q == IDLE);
  assign push      = tag_v_q;
  assign pop       = DOUT_VALID && DOUT_READY;
  assign head_last = mem_q[rd_q][16];

  // Credit ignores a same-cycle pop, so the FIFO can never be oversubscribed.
  assign used   = {1'b0, count_q} + {{CW{1'b0}}, tag_v_q};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign issue  = (state_q == ISSUE) && credit;

`ifdef ROM_READER_BOUND_CHECK_EN
  logic [20:0] end_addr;
  logic        err_q, err_d;

  assign end_addr = {1'b0, REQ_ADDR} + {11'b0, REQ_LEN};
  assign reject   = end_addr > 21'd786431;

  always_comb begin
    err_d = err_q;
    if (accept) err_d = reject;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q;
`else
  assign reject = 1'b0;
  assign ERR    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rom_a_d    = rom_a_q;
    rom_oe_d   = rom_oe_q;
    cnt_d      = cnt_q;
    tag_v_d    = 1'b0;
    tag_last_d = 1'b0;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;

    if (push) begin
      mem_d[wr_q] = {tag_last_q, ROM_Q};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // The tag rides one edge behind ROM_A, matching the ROM's registered read.
    if (issue) begin
      tag_v_d    = 1'b1;
      tag_last_d = (cnt_q == 10'd0);
    end

    case (state_q)
      IDLE: begin
        if (accept && !reject) begin
          rom_a_d  = REQ_ADDR;
          rom_oe_d = 1'b1;
          cnt_d    = REQ_LEN;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          rom_a_d = rom_a_q + 20'd1;
          if (cnt_q == 10'd0) state_d = DRAIN;
          else                cnt_d   = cnt_q - 10'd1;
        end
      end
      DRAIN: begin
        if (push && tag_last_q) rom_oe_d = 1'b0;
        if (pop && head_last)   state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rom_a_q    <= 20'd0;
      rom_oe_q   <= 1'b0;
      cnt_q      <= 10'd0;
      tag_v_q    <= 1'b0;
      tag_last_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 17'd0;
    end else begin
      state_q    <= state_d;
      rom_a_q    <= rom_a_d;
      rom_oe_q   <= rom_oe_d;
      cnt_q      <= cnt_d;
      tag_v_q    <= tag_v_d;
      tag_last_q <= tag_last_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign REQ_READY  = (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign ROM_A      = rom_a_q;
  assign ROM_OE     = rom_oe_q;
  assign DOUT_VALID = (count_q != '0);
  assign DOUT_DATA  = mem_q[rd_q][15:0];
  assign DOUT_LAST  = head_last;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: a ROM model, a queue-based expected-beat model and
// one negedge compare process, driven by directed bursts plus randomized requests.
module tb_rom_reader;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [19:0] REQ_ADDR = 20'd0;
  logic [9:0]  REQ_LEN = 10'd0;
  logic [19:0] ROM_A;
  logic        ROM_OE;
  logic [15:0] ROM_Q;
  logic        DOUT_VALID;
  logic        DOUT_READY = 1'b0;
  logic [15:0] DOUT_DATA;
  logic        DOUT_LAST;
  logic        BUSY;
  logic        ERR;
  logic [1:0]  dbg_state;

  rom_reader #(.FIFO_DEPTH(4)) dut (
    .CK(CK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .ROM_A(ROM_A), .ROM_OE(ROM_OE),
    .ROM_Q(ROM_Q), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_DATA(DOUT_DATA), .DOUT_LAST(DOUT_LAST), .BUSY(BUSY), .ERR(ERR),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CK = ~CK;

  // ---------------- ROM contents and ROM model ----------------
  function automatic logic [15:0] mem_f(input logic [19:0] a);
    logic [15:0] m;
    m = a[15:0] * 16'd7;
    return m ^ {a[19:16], 12'hC3A};
  endfunction

  logic [15:0] rom_q_r;
  always @(posedge CK) rom_q_r <= mem_f(ROM_A);
  assign ROM_Q = rom_q_r;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  bit          err_m = 1'b0;
  bit          acc_flag = 1'b0;
  logic [19:0] acc_addr = 20'd0;
  int          pops = 0;
  int          hold_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [16:0] prev_beat = 17'd0;
  bit          prev_oe = 1'b0;
  logic [19:0] prev_a = 20'd0;
  int          rdy_mode = 0;
  int          rdy_ph = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  function automatic bit rejected(input logic [19:0] a, input logic [9:0] l);
`ifdef ROM_READER_BOUND_CHECK_EN
    return (int'(a) + int'(l)) > 786431;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge CK) begin
    if (RST) begin
      prev_stall = 1'b0;
      prev_oe    = 1'b0;
    end else begin
      chk("busy", BUSY, exp_q.size() != 0);
      chk("req_ready", REQ_READY, exp_q.size() == 0);
      chk("err", ERR, err_m);
      if (exp_q.size() == 0) chk("rom_oe_idle", ROM_OE, 1'b0);
      if (acc_flag) begin
        chk("rom_oe_start", ROM_OE, 1'b1);
        chk("rom_a_start", ROM_A, acc_addr);
        acc_flag = 1'b0;
      end else if (prev_oe && ROM_OE) begin
        chk("rom_a_step", (ROM_A == prev_a) || (ROM_A == prev_a + 20'd1), 1'b1);
        if (ROM_A == prev_a) hold_cnt++;
      end
      if (prev_stall) begin
        chk("hold_valid", DOUT_VALID, 1'b1);
        chk("hold_data", {DOUT_LAST, DOUT_DATA}, prev_beat);
      end
      if (DOUT_VALID) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          chk("dout_data", DOUT_DATA, exp_q[0][15:0]);
          chk("dout_last", DOUT_LAST, exp_q[0][16]);
          if (DOUT_READY) begin
            void'(exp_q.pop_front());
            got_q.push_back({DOUT_LAST, DOUT_DATA});
            pops++;
          end
        end
      end
      prev_stall = DOUT_VALID && !DOUT_READY;
      prev_beat  = {DOUT_LAST, DOUT_DATA};
      prev_oe    = ROM_OE;
      prev_a     = ROM_A;
    end
  end

  // ---------------- DOUT_READY driver ----------------
  initial forever begin
    @(posedge CK);
    #1;
    case (rdy_mode)
      0: DOUT_READY = 1'b1;
      1: begin
        DOUT_READY = (rdy_ph == 0);
        rdy_ph = (rdy_ph + 1) % 4;
      end
      default: DOUT_READY = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- request driver ----------------
  task automatic send(input logic [19:0] a, input logic [9:0] l);
    int n;
    logic [19:0] ai;
    @(negedge CK);
    REQ_ADDR  = a;
    REQ_LEN   = l;
    REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 5000) begin
      @(negedge CK);
      n++;
    end
    if (n >= 5000) begin
      fail_now("req_ready_timeout");
      REQ_VALID = 1'b0;
      return;
    end
    @(posedge CK);
    if (rejected(a, l)) begin
      err_m = 1'b1;
    end else begin
      err_m = 1'b0;
      for (int i = 0; i <= int'(l); i++) begin
        ai = a + 20'(i);
        exp_q.push_back({(i == int'(l)), mem_f(ai)});
      end
      acc_addr = a;
      acc_flag = 1'b1;
    end
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 20000) begin
      @(negedge CK);
      n++;
    end
    if (n >= 20000) fail_now("idle_timeout");
    @(negedge CK);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int p0;
    logic [19:0] ra;

    #3;
    chk("rst_dout_valid", DOUT_VALID, 1'b0);
    chk("rst_dout_data", DOUT_DATA, 16'h0000);
    chk("rst_dout_last", DOUT_LAST, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_rom_a", ROM_A, 20'h00000);
    chk("rst_rom_oe", ROM_OE, 1'b0);
    @(posedge CK);
    @(posedge CK);
    #2 RST = 1'b0;
    @(negedge CK);
    chk("rst_req_ready", REQ_READY, 1'b1);

    // Single word: first valid after edge 2, literal data pins the model.
    rdy_mode = 0;
    send(20'h00010, 10'd0);
    @(negedge CK);
    chk("lat_e0", DOUT_VALID, 1'b0);
    @(negedge CK);
    chk("lat_e1", DOUT_VALID, 1'b0);
    @(negedge CK);
    chk("lat_e2", DOUT_VALID, 1'b1);
    chk("single_data", DOUT_DATA, 16'h0C4A);
    chk("single_last", DOUT_LAST, 1'b1);
    wait_idle();
    chk("single_busy_end", BUSY, 1'b0);

    // Streaming: 16 beats on consecutive cycles.
    send(20'd100, 10'd15);
    n = 0;
    @(negedge CK);
    while (!DOUT_VALID && n < 50) begin
      @(negedge CK);
      n++;
    end
    if (n >= 50) fail_now("stream_start");
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", DOUT_VALID, 1'b1);
      chk("stream_last", DOUT_LAST, (i == 15));
      @(negedge CK);
    end
    wait_idle();

    // Backpressure 1 on / 3 off.
    rdy_mode = 1;
    hold_cnt = 0;
    p0 = pops;
    send(20'h0A5A5, 10'd31);
    wait_idle();
    chk("bp_count", pops - p0, 32);
    chk("bp_rom_a_held", hold_cnt > 0, 1'b1);

    // Reset in the middle of a long burst.
    rdy_mode = 0;
    p0 = pops;
    send(20'd200, 10'd63);
    n = 0;
    while (pops - p0 < 10 && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (n >= 200) fail_now("mid_reset_wait");
    #2 RST = 1'b1;
    exp_q.delete();
    err_m    = 1'b0;
    acc_flag = 1'b0;
    #1;
    chk("mid_rst_valid", DOUT_VALID, 1'b0);
    chk("mid_rst_data", DOUT_DATA, 16'h0000);
    chk("mid_rst_last", DOUT_LAST, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_rom_a", ROM_A, 20'h00000);
    chk("mid_rst_rom_oe", ROM_OE, 1'b0);
    @(posedge CK);
    @(posedge CK);
    #2 RST = 1'b0;
    got_q.delete();
    send(20'd0, 10'd3);
    wait_idle();
    repeat (5) @(negedge CK);
    chk("post_rst_count", got_q.size(), 4);
    if (got_q.size() == 4) chk("post_rst_w0", got_q[0], {1'b0, 16'h0C3A});

`ifdef ROM_READER_BOUND_CHECK_EN
    send(20'd786430, 10'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      chk("bound_err", ERR, 1'b1);
      chk("bound_oe", ROM_OE, 1'b0);
      chk("bound_no_beat", DOUT_VALID, 1'b0);
    end
    got_q.delete();
    send(20'd786429, 10'd2);
    wait_idle();
    chk("bound_edge_err", ERR, 1'b0);
    chk("bound_edge_count", got_q.size(), 3);
`else
    got_q.delete();
    send(20'hFFFFE, 10'd3);
    wait_idle();
    chk("wrap_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("wrap_w0", got_q[0], {1'b0, 16'h03C8});
      chk("wrap_w2", got_q[2], {1'b0, 16'h0C3A});
      chk("wrap_w3_last", got_q[3][16], 1'b1);
    end
    chk("wrap_err", ERR, 1'b0);
`endif

    // Maximum burst length.
    rdy_mode = 0;
    p0 = pops;
    send(20'h12345, 10'd1023);
    wait_idle();
    chk("max_len_count", pops - p0, 1024);

    // Randomized requests with random backpressure.
    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      ra = 20'($urandom_range(0, 20'hFFFFF));
      if (k % 5 == 0) ra = 20'hFFFF0;
      send(ra, 10'($urandom_range(0, 40)));
      repeat ($urandom_range(0, 3)) @(negedge CK);
    end
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
